// File: rtl/uart_tx_if.sv
// uart_tx_if: request/line bundle between a UART TX client and uart_tx.
// master drives p_data/data_valid/par_en/par_typ; slave drives tx_out/busy.
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_en;
  logic                  par_typ;
  logic                  tx_out;
  logic                  busy;

  modport master (
    output p_data,
    output data_valid,
    output par_en,
    output par_typ,
    input  tx_out,
    input  busy
  );

  modport slave (
    input  p_data,
    input  data_valid,
    input  par_en,
    input  par_typ,
    output tx_out,
    output busy
  );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: serialises one byte per frame (start, data LSB first,
// optional parity, stop); one clk cycle is one bit period.
// Ports: clk, rst (async, active high), bus (uart_tx_if.slave):
//   p_data, data_valid, par_en, par_typ in; tx_out, busy out (registered).
// Build option: define UART_TX_PARITY_EN to compile in the parity bit;
// without it par_en/par_typ are present but ignored.
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);

  localparam int CW =
    (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_tx;
  logic                  r_busy;
  logic                  w_tx_nxt;
  logic                  w_busy_nxt;
  logic                  w_accept;

`ifdef UART_TX_PARITY_EN
  logic r_par_en;
  logic r_par;
`else
  logic w_unused;
  assign w_unused = bus.par_en ^ bus.par_typ;
`endif

  // Only IDLE accepts; requests while busy are dropped.
  assign w_accept = (r_state == S_IDLE) & bus.data_valid;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Holding registers: the frame is built only from these,
  // so the input bus may change freely once accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data   <= '0;
`ifdef UART_TX_PARITY_EN
      r_par_en <= 1'b0;
      r_par    <= 1'b0;
`endif
    end else if (w_accept) begin
      r_data   <= bus.p_data;
`ifdef UART_TX_PARITY_EN
      r_par_en <= bus.par_en;
      r_par    <= bus.par_typ ? ~^bus.p_data
                              :  ^bus.p_data;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (bus.data_valid) w_next = S_START;
      end
      S_START: begin
        w_next    = S_DATA;
        w_cnt_nxt = '0;
      end
      S_DATA: begin
        if (r_cnt == LAST) begin
          w_cnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
          w_next = r_par_en ? S_PARITY : S_STOP;
`else
          w_next = S_STOP;
`endif
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        w_next = S_STOP;
      end
`endif
      S_STOP: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next    = S_IDLE;
        w_cnt_nxt = '0;
      end
    endcase
  end

  // Output logic: decoded from the upcoming state so the
  // line and busy flags are flops aligned with that state.
  always_comb begin
    w_tx_nxt   = 1'b1;
    w_busy_nxt = 1'b1;
    unique case (w_next)
      S_IDLE: begin
        w_busy_nxt = 1'b0;
      end
      S_START: begin
        w_tx_nxt = 1'b0;
      end
      S_DATA: begin
        w_tx_nxt = r_data[w_cnt_nxt];
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        w_tx_nxt = r_par;
      end
`endif
      S_STOP: begin
        w_tx_nxt = 1'b1;
      end
      default: begin
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx   <= 1'b1;
      r_busy <= 1'b0;
    end else begin
      r_tx   <= w_tx_nxt;
      r_busy <= w_busy_nxt;
    end
  end

  assign bus.tx_out = r_tx;
  assign bus.busy   = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized self-checking bench for uart_tx against
// a frame-level reference model.
module tb_uart_tx;

  localparam int W = 8;
`ifdef UART_TX_PARITY_EN
  localparam bit HAS_PAR = 1'b1;
`else
  localparam bit HAS_PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  uart_tx_if #(.DATA_WIDTH(W)) bus ();

  uart_tx #(.DATA_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Frame length in bit periods.
  function automatic int flen(input bit pe);
    return 2 + W + ((HAS_PAR && pe) ? 1 : 0);
  endfunction

  // Expected line level at bit position idx of a frame.
  function automatic logic exp_bit(input logic [W-1:0] d,
                                   input bit pe,
                                   input bit pt,
                                   input int idx);
    int ones;
    if (idx == 0) return 1'b0;
    if (idx <= W) return d[idx-1];
    if (HAS_PAR && pe && idx == W + 1) begin
      ones = $countones(d);
      // even: bit makes total count even; odd: total odd
      return pt ? ((ones % 2) == 0) : ((ones % 2) == 1);
    end
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one frame from idle and checks every bit plus the
  // following idle cycle. scramble perturbs inputs mid-frame.
  task automatic run_frame(input logic [W-1:0] d,
                           input bit pe,
                           input bit pt,
                           input bit scramble,
                           input string tag);
    int L;
    L = flen(pe);
    bus.p_data     = d;
    bus.par_en     = pe;
    bus.par_typ    = pt;
    bus.data_valid = 1'b1;
    tick();
    bus.data_valid = 1'b0;
    for (int i = 0; i < L; i++) begin
      if (scramble) begin
        bus.p_data     = W'($urandom);
        bus.par_en     = 1'($urandom);
        bus.par_typ    = 1'($urandom);
        bus.data_valid = 1'($urandom);
      end
      n_tests++;
      if (bus.tx_out !== exp_bit(d, pe, pt, i) ||
          bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s bit%0d: tx_out=%b busy=%b, need %b/1",
                 tag, i, bus.tx_out, bus.busy,
                 exp_bit(d, pe, pt, i));
      end
      tick();
    end
    bus.data_valid = 1'b0;
    n_tests++;
    if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle: tx_out=%b busy=%b, need 1/0",
               tag, bus.tx_out, bus.busy);
    end
    tick();
  endtask

  task automatic test_reset();
    bus.p_data     = '0;
    bus.par_en     = 1'b0;
    bus.par_typ    = 1'b0;
    bus.data_valid = 1'b0;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: tx_out=%b busy=%b, need 1/0",
               bus.tx_out, bus.busy);
    end
    tick();
    tick();
    #2;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle%0d: tx_out=%b busy=%b, need 1/0",
                 i, bus.tx_out, bus.busy);
      end
    end
  endtask

  task automatic test_no_parity();
    run_frame(8'hA5, 1'b0, 1'b0, 1'b0, "nopar_A5");
  endtask

  task automatic test_parity();
    run_frame(8'hA5, 1'b1, 1'b0, 1'b0, "par_even_A5");
    run_frame(8'hA5, 1'b1, 1'b1, 1'b0, "par_odd_A5");
    run_frame(8'h01, 1'b1, 1'b0, 1'b1, "par_even_01_scr");
    run_frame(8'h01, 1'b1, 1'b1, 1'b0, "par_odd_01");
  endtask

  task automatic test_random();
    for (int k = 0; k < 30; k++) begin
      run_frame(W'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), "random");
    end
  endtask

  task automatic test_back_to_back();
    int   L;
    int   first;
    int   second;
    logic prev_busy;
    logic et;
    logic eb;
    L         = flen(1'b0);
    first     = -1;
    second    = -1;
    prev_busy = 1'b0;
    bus.par_en     = 1'b0;
    bus.par_typ    = 1'b0;
    bus.p_data     = 8'h3C;
    bus.data_valid = 1'b1;
    tick();
    bus.p_data = 8'hC3;
    for (int c = 0; c < 2 * L + 3; c++) begin
      if (c == L + 1) bus.data_valid = 1'b0;
      if (c < L) begin
        et = exp_bit(8'h3C, 1'b0, 1'b0, c);
        eb = 1'b1;
      end else if (c == L) begin
        et = 1'b1;
        eb = 1'b0;
      end else if (c < 2 * L + 1) begin
        et = exp_bit(8'hC3, 1'b0, 1'b0, c - L - 1);
        eb = 1'b1;
      end else begin
        et = 1'b1;
        eb = 1'b0;
      end
      if (bus.busy === 1'b1 && prev_busy === 1'b0) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
      prev_busy = bus.busy;
      n_tests++;
      if (bus.tx_out !== et || bus.busy !== eb) begin
        n_fail++;
        $display("FAIL b2b cyc%0d: tx_out=%b busy=%b, need %b/%b",
                 c, bus.tx_out, bus.busy, et, eb);
      end
      tick();
    end
    n_tests++;
    if (second - first != L + 1) begin
      n_fail++;
      $display("FAIL b2b_spacing: got %0d cycles, need %0d",
               second - first, L + 1);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [W-1:0] d;
    d = W'($urandom);
    bus.p_data     = d;
    bus.par_en     = 1'b0;
    bus.par_typ    = 1'b0;
    bus.data_valid = 1'b1;
    tick();
    bus.data_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    n_tests++;
    if (bus.tx_out !== d[4] || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_bit4: tx_out=%b busy=%b, need %b/1",
               bus.tx_out, bus.busy, d[4]);
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_abort: tx_out=%b busy=%b, need 1/0",
               bus.tx_out, bus.busy);
    end
    tick();
    tick();
    #2;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_tests++;
      if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_no_resume%0d: tx_out=%b busy=%b, need 1/0",
                 i, bus.tx_out, bus.busy);
      end
    end
    run_frame(W'($urandom), 1'($urandom), 1'($urandom),
              1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_no_parity();
    test_parity();
    test_random();
    test_back_to_back();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
